// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter (shift-and-add-3, one
// input bit per clock) for the three-digit seven-segment display driver.
// Results above 999 saturate to 999 and raise ovf.
//
// Ports:
//   clk   - system clock, rising edge
//   rst   - asynchronous reset, active low
//   start - conversion request, sampled only while idle
//   bin   - W-bit binary operand, captured on the accepted start edge
//   busy  - high while a conversion is in progress
//   done  - one-cycle pulse when a new result is presented on bcd
//   bcd   - packed digits: [3:0] ones, [7:4] tens, [11:8] hundreds
//   ovf   - captured operand was above 999; valid alongside bcd
module bin2bcd_seq #(
   parameter int unsigned W = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] bin,
   output logic         busy,
   output logic         done,
   output logic [11:0]  bcd,
   output logic         ovf
);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_e;

   state_e       state_q, state_d;
   logic [W-1:0] op_q, op_d;
   logic [11:0]  scr_q, scr_d;
   logic [11:0]  scr_adj;
   logic [3:0]   cnt_q, cnt_d;
   logic         ovfp_q, ovfp_d;
   logic         busy_q, busy_d;
   logic         done_q, done_d;
   logic [11:0]  bcd_q, bcd_d;
   logic         ovf_q, ovf_d;
   logic [10:0]  bin_ext;

   // Widened so the >999 test is well formed for every legal W; for W<10
   // the comparison is constant-false and ovf never rises.
   assign bin_ext = 11'(bin);

   // Per-digit add-3 correction applied before each shift; digits are
   // corrected independently with no carry between them.
   always_comb begin
      scr_adj = scr_q;
      for (int unsigned d = 0; d < 3; d++) begin
         if (scr_q[4*d +: 4] >= 4'd5) begin
            scr_adj[4*d +: 4] = scr_q[4*d +: 4] + 4'd3;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      scr_d   = scr_q;
      cnt_d   = cnt_q;
      ovfp_d  = ovfp_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      bcd_d   = bcd_q;
      ovf_d   = ovf_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               op_d    = bin;
               scr_d   = '0;
               cnt_d   = 4'(W);
               ovfp_d  = (bin_ext > 11'd999);
               busy_d  = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            scr_d = {scr_adj[10:0], op_q[W-1]};
            op_d  = op_q << 1;
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = DONE;
            end
         end
         DONE: begin
            // Saturation overrides whatever the scratch holds, since
            // operands >= 1000 overflow the three-digit scratch.
            bcd_d   = ovfp_q ? 12'h999 : scr_q;
            ovf_d   = ovfp_q;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         op_q    <= '0;
         scr_q   <= '0;
         cnt_q   <= '0;
         ovfp_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         bcd_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         scr_q   <= scr_d;
         cnt_q   <= cnt_d;
         ovfp_q  <= ovfp_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         bcd_q   <= bcd_d;
         ovf_q   <= ovf_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign bcd  = bcd_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Testbench for bin2bcd_seq (W=10): a cycle-level reference model built
// from decimal arithmetic and a busy-countdown, checked against the DUT on
// every falling edge, plus directed conversions with literal expectations.
module tb_bin2bcd_seq;

   localparam int unsigned W = 10;

   logic          clk;
   logic          rst;
   logic          start;
   logic [W-1:0]  bin;
   logic          busy;
   logic          done;
   logic [11:0]   bcd;
   logic          ovf;

   int n_checks = 0;
   int n_pass   = 0;

   bin2bcd_seq #(.W(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .bcd   (bcd),
      .ovf   (ovf)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [11:0] to_bcd(input int v);
      int s;
      s = (v > 999) ? 999 : v;
      return {4'(s / 100), 4'((s / 10) % 10), 4'(s % 10)};
   endfunction

   // Reference model: a conversion keeps busy high for W+1 cycles after the
   // accepting edge, then publishes the decimal result with a done pulse.
   int          m_left;
   int          m_val;
   logic        m_busy;
   logic        m_done;
   logic [11:0] m_bcd;
   logic        m_ovf;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_left <= 0;
         m_val  <= 0;
         m_busy <= 1'b0;
         m_done <= 1'b0;
         m_bcd  <= '0;
         m_ovf  <= 1'b0;
      end else begin
         m_done <= 1'b0;
         if (m_left == 0) begin
            if (start) begin
               m_left <= W + 1;
               m_val  <= int'(bin);
               m_busy <= 1'b1;
            end
         end else begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
               m_busy <= 1'b0;
               m_done <= 1'b1;
               m_bcd  <= to_bcd(m_val);
               m_ovf  <= (m_val > 999);
            end
         end
      end
   end

   always @(negedge clk) begin
      check("cyc_busy", 32'(busy), 32'(m_busy));
      check("cyc_done", 32'(done), 32'(m_done));
      check("cyc_bcd",  32'(bcd),  32'(m_bcd));
      check("cyc_ovf",  32'(ovf),  32'(m_ovf));
   end

   task automatic wait_done(input int inj_at, input logic [W-1:0] inj_bin,
                            output int lat, output int nbusy, output bit got);
      lat   = 0;
      nbusy = 0;
      got   = 1'b0;
      for (int k = 0; k < 40 && !got; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (k == inj_at) begin
            start = 1'b1;
            bin   = inj_bin;
         end
         if (done) begin
            got = 1'b1;
            lat = k;
         end else if (busy) begin
            nbusy++;
         end
      end
   endtask

   task automatic conv(input string name, input logic [W-1:0] b, input logic [11:0] eb,
                       input logic eo, input int inj_at, input logic [W-1:0] ib,
                       input bit at_once);
      int lat;
      int nbusy;
      bit got;
      if (!at_once) @(negedge clk);
      start = 1'b1;
      bin   = b;
      wait_done(inj_at, ib, lat, nbusy, got);
      check({name, "_done_seen"}, 32'(got), 32'd1);
      check({name, "_latency"}, 32'(lat), 32'd11);
      check({name, "_busy_cycles"}, 32'(nbusy), 32'd11);
      check({name, "_bcd"}, 32'(bcd), 32'(eb));
      check({name, "_ovf"}, 32'(ovf), 32'(eo));
   endtask

   initial begin
      int extra;
      rst   = 1'b0;
      start = 1'b0;
      bin   = '0;

      // Reset held with random activity on the inputs.
      repeat (6) begin
         @(negedge clk);
         start = 1'($urandom_range(0, 1));
         bin   = W'($urandom_range(0, 1023));
      end
      @(negedge clk);
      start = 1'b0;
      check("rst_bcd",  32'(bcd),  32'h000);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_ovf",  32'(ovf),  32'd0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      conv("c255", 10'd255, 12'h255, 1'b0, -1, '0, 1'b0);
      conv("c0",   10'd0,   12'h000, 1'b0, -1, '0, 1'b0);
      conv("c9",   10'd9,   12'h009, 1'b0, -1, '0, 1'b0);
      conv("c10",  10'd10,  12'h010, 1'b0, -1, '0, 1'b0);
      conv("c999", 10'd999, 12'h999, 1'b0, -1, '0, 1'b0);
      conv("c1000", 10'd1000, 12'h999, 1'b1, -1, '0, 1'b0);
      conv("c1023", 10'd1023, 12'h999, 1'b1, -1, '0, 1'b0);
      conv("c42",  10'd42,  12'h042, 1'b0, -1, '0, 1'b0);

      // start while busy is dropped, leaving exactly one done pulse.
      conv("c123_ign", 10'd123, 12'h123, 1'b0, 5, 10'd456, 1'b0);
      extra = 0;
      repeat (14) begin
         @(negedge clk);
         if (done) extra++;
      end
      check("ign_single_done", 32'(extra), 32'd0);

      // start on the done cycle is accepted.
      conv("c100", 10'd100, 12'h100, 1'b0, -1, '0, 1'b0);
      conv("c456_b2b", 10'd456, 12'h456, 1'b0, -1, '0, 1'b1);

      // Asynchronous reset mid-conversion.
      @(negedge clk);
      start = 1'b1;
      bin   = 10'd777;
      repeat (6) begin
         @(negedge clk);
         start = 1'b0;
      end
      check("mid_busy_before", 32'(busy), 32'd1);
      #2 rst = 1'b0;
      #1;
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_done", 32'(done), 32'd0);
      check("mid_rst_bcd",  32'(bcd),  32'h000);
      check("mid_rst_ovf",  32'(ovf),  32'd0);
      repeat (3) begin
         @(negedge clk);
         start = 1'($urandom_range(0, 1));
         bin   = W'($urandom_range(0, 1023));
      end
      @(negedge clk);
      start = 1'b0;
      rst   = 1'b1;
      repeat (3) @(negedge clk);
      check("post_rst_idle", 32'(busy), 32'd0);
      conv("c321", 10'd321, 12'h321, 1'b0, -1, '0, 1'b0);

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
